// File: rtl/neo_bus_pkg.sv
// Shared types and constants for the 68K-style bus initiator and its helpers.
package neo_bus_pkg;

  localparam int unsigned ADDR_W      = 23;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BE_W        = 2;
  localparam int unsigned WD_W        = 8;
  localparam int unsigned TIMEOUT_DEF = 64;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bus cycle phases; STRB is only visited by writes.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_STRB = 3'd2,
    ST_WAIT = 3'd3,
    ST_TERM = 3'd4
  } bus_state_e;

  // Latched request payload (address goes straight to the bus register).
  typedef struct packed {
    logic              rw;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/m68k_bus_watchdog.sv
// Saturating 8-bit wait watchdog, advanced only on clock-enable ticks.
// Ports: CLK/nRESET clock and async reset; i_en tick enable; i_clr clear;
//        i_inc increment; o_last_c high when the next increment reaches TIMEOUT.
module m68k_bus_watchdog
  import neo_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last_c
);

  logic [WD_W-1:0] r_cnt;

  // Counter saturates at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc && (r_cnt != {WD_W{1'b1}})) begin
        r_cnt <= r_cnt + WD_W'(1);
      end
    end
  end

  assign o_last_c = (r_cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68K-style bus cycle initiator: one word request -> nAS/nUDS/nLDS/RW cycle,
// waits for nDTACK, aborts with BERR on watchdog timeout.
// Ports: CLK, nRESET, CLK_EN_68K_P (E tick); REQ/REQ_RW/REQ_ADDR/REQ_WDATA/REQ_BE
//        request side; BUSY/ACK/BERR/RDATA completion side; M68K_* , nAS, nUDS,
//        nLDS, nDTACK bus side.
module m68k_bus_initiator
  import neo_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              CLK_EN_68K_P,
  input  logic              REQ,
  input  logic              REQ_RW,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [BE_W-1:0]   REQ_BE,
  output logic              BUSY,
  output logic              ACK,
  output logic              BERR,
  output logic [DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0] M68K_ADDR,
  output logic [DATA_W-1:0] M68K_DOUT,
  output logic              M68K_DOUT_EN,
  input  logic [DATA_W-1:0] M68K_DIN,
  output logic              nAS,
  output logic              nUDS,
  output logic              nLDS,
  output logic              M68K_RW,
  input  logic              nDTACK
);

  bus_state_e        r_state, w_state;
  bus_req_t          r_req, w_req;
  logic              r_abort, w_abort;
  logic              r_nas, w_nas, r_nuds, w_nuds, r_nlds, w_nlds, r_rw, w_rw;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_dout, w_dout, r_rdata, w_rdata;
  logic              r_dout_en, w_dout_en, r_busy, w_busy;
  logic              r_ack, w_ack, r_berr, w_berr;
  logic              w_wd_clr, w_wd_inc, w_wd_last;

  m68k_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .i_en     (CLK_EN_68K_P),
    .i_clr    (w_wd_clr),
    .i_inc    (w_wd_inc),
    .o_last_c (w_wd_last)
  );

  // State and output registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_abort   <= 1'b0;
      r_nas     <= 1'b1;
      r_nuds    <= 1'b1;
      r_nlds    <= 1'b1;
      r_rw      <= RW_READ;
      r_addr    <= '0;
      r_dout    <= '0;
      r_rdata   <= '0;
      r_dout_en <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_berr    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_req     <= w_req;
      r_abort   <= w_abort;
      r_nas     <= w_nas;
      r_nuds    <= w_nuds;
      r_nlds    <= w_nlds;
      r_rw      <= w_rw;
      r_addr    <= w_addr;
      r_dout    <= w_dout;
      r_rdata   <= w_rdata;
      r_dout_en <= w_dout_en;
      r_busy    <= w_busy;
      r_ack     <= w_ack;
      r_berr    <= w_berr;
    end
  end

  // Next-state and next-output logic; everything advances on E only,
  // except ACK which self-clears on the following CLK.
  always_comb begin
    w_state   = r_state;
    w_req     = r_req;
    w_abort   = r_abort;
    w_nas     = r_nas;
    w_nuds    = r_nuds;
    w_nlds    = r_nlds;
    w_rw      = r_rw;
    w_addr    = r_addr;
    w_dout    = r_dout;
    w_rdata   = r_rdata;
    w_dout_en = r_dout_en;
    w_busy    = r_busy;
    w_ack     = 1'b0;
    w_berr    = r_berr;
    w_wd_clr  = 1'b0;
    w_wd_inc  = 1'b0;

    if (CLK_EN_68K_P) begin
      case (r_state)
        ST_IDLE: begin
          if (REQ) begin
            w_req   = '{rw: REQ_RW, be: REQ_BE, wdata: REQ_WDATA};
            w_addr  = REQ_ADDR;
            w_rw    = REQ_RW;
            w_busy  = 1'b1;
            w_abort = 1'b0;
            // No lanes enabled: complete without touching the strobes.
            w_state = (REQ_BE == 2'b00) ? ST_TERM : ST_ADDR;
          end
        end
        ST_ADDR: begin
          w_nas = 1'b0;
          if (r_req.rw == RW_READ) begin
            w_nuds  = ~r_req.be[1];
            w_nlds  = ~r_req.be[0];
            w_state = ST_WAIT;
          end else begin
            w_dout    = r_req.wdata;
            w_dout_en = 1'b1;
            w_state   = ST_STRB;
          end
        end
        ST_STRB: begin
          w_nuds  = ~r_req.be[1];
          w_nlds  = ~r_req.be[0];
          w_state = ST_WAIT;
        end
        ST_WAIT: begin
          if (!nDTACK) begin
            if (r_req.rw == RW_READ) begin
              w_rdata = M68K_DIN;
            end
            w_state = ST_TERM;
          end else begin
            w_wd_inc = 1'b1;
            if (w_wd_last) begin
              w_abort = 1'b1;
              w_state = ST_TERM;
            end
          end
        end
        ST_TERM: begin
          w_nas     = 1'b1;
          w_nuds    = 1'b1;
          w_nlds    = 1'b1;
          w_rw      = RW_READ;
          w_dout_en = 1'b0;
          w_ack     = 1'b1;
          w_berr    = r_abort;
          w_busy    = 1'b0;
          w_wd_clr  = 1'b1;
          w_state   = ST_IDLE;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY         = r_busy;
  assign ACK          = r_ack;
  assign BERR         = r_berr;
  assign RDATA        = r_rdata;
  assign M68K_ADDR    = r_addr;
  assign M68K_DOUT    = r_dout;
  assign M68K_DOUT_EN = r_dout_en;
  assign nAS          = r_nas;
  assign nUDS         = r_nuds;
  assign nLDS         = r_nlds;
  assign M68K_RW      = r_rw;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Scoreboard bench for m68k_bus_initiator: stimulus pushes expected completions,
// a monitor pops and checks them on each ACK pulse.
module tb_m68k_bus_initiator;
  import neo_bus_pkg::*;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        CLK_EN_68K_P = 1'b0;
  logic        REQ = 1'b0;
  logic        REQ_RW = 1'b1;
  logic [22:0] REQ_ADDR = '0;
  logic [15:0] REQ_WDATA = '0;
  logic [1:0]  REQ_BE = '0;
  logic        BUSY, ACK, BERR, M68K_DOUT_EN, nAS, nUDS, nLDS, M68K_RW, nDTACK;
  logic [15:0] RDATA, M68K_DOUT;
  logic [15:0] M68K_DIN = '0;
  logic [22:0] M68K_ADDR;

  m68k_bus_initiator dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_EN_68K_P(CLK_EN_68K_P),
    .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_BE(REQ_BE), .BUSY(BUSY), .ACK(ACK), .BERR(BERR), .RDATA(RDATA),
    .M68K_ADDR(M68K_ADDR), .M68K_DOUT(M68K_DOUT), .M68K_DOUT_EN(M68K_DOUT_EN),
    .M68K_DIN(M68K_DIN), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
    .M68K_RW(M68K_RW), .nDTACK(nDTACK)
  );

  always #5 CLK = ~CLK;

  // E tick every second CLK.
  always @(negedge CLK) CLK_EN_68K_P = ~CLK_EN_68K_P;

  int e_num = 0;
  always @(posedge CLK) if (CLK_EN_68K_P) e_num <= e_num + 1;

  // DTACK sources: 0 = tied to nAS, 1 = 5-preset down-counter zone, 2 = stuck high.
  int dmode = 0;
  logic [2:0] zcnt = 3'd5;
  always @(posedge CLK) begin
    if (CLK_EN_68K_P) zcnt <= nAS ? 3'd5 : ((zcnt != 0) ? zcnt - 3'd1 : 3'd0);
  end
  assign nDTACK = (dmode == 0) ? nAS :
                  (dmode == 1) ? !((nAS == 1'b0) && (zcnt <= 3'd3)) : 1'b1;

  typedef struct {
    int          ack_e;
    logic        berr;
    logic [15:0] rdata;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (E=%0d)", name, act, exp, e_num);
    end
  endtask

  // Monitor: every rising ACK must match the oldest expected completion.
  logic prev_ack = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (prev_ack) chk("ack_width", 32'(ACK), 32'd0);
    if (ACK && !prev_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ACK=1 expected no ACK (E=%0d)", e_num);
      end else begin
        e = sb_q.pop_front();
        chk({e.tag, "_ack_e"}, 32'(e_num), 32'(e.ack_e));
        chk({e.tag, "_berr"},  32'(BERR),  32'(e.berr));
        chk({e.tag, "_rdata"}, 32'(RDATA), 32'(e.rdata));
        chk({e.tag, "_busy"},  32'(BUSY),  32'd0);
      end
    end
    prev_ack = ACK;
  end

  // Present a request just before an E edge; returns the accepting E number.
  task automatic issue(input logic rw, input logic [22:0] addr, input logic [15:0] wd,
                       input logic [1:0] be, input int lat, input logic berr,
                       input logic [15:0] rd, input string tag, input bit hold,
                       output int e0);
    int guard = 0;
    exp_t e;
    do begin
      @(negedge CLK); #1;
      guard++;
    end while (!(CLK_EN_68K_P && !BUSY) && guard < 2000);
    if (guard >= 2000) chk({tag, "_ready_timeout"}, 32'(BUSY), 32'd0);
    REQ_RW = rw; REQ_ADDR = addr; REQ_WDATA = wd; REQ_BE = be; REQ = 1'b1;
    e0 = e_num + 1;
    e.ack_e = e0 + lat; e.berr = berr; e.rdata = rd; e.tag = tag;
    sb_q.push_back(e);
    @(negedge CLK); #1;
    if (!hold) REQ = 1'b0;
  endtask

  task automatic wait_e(input int target);
    int guard = 0;
    while (e_num < target && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 5000) chk("wait_e_timeout", 32'(e_num), 32'(target));
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 5000) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_nas", 32'(nAS), 32'd1);
    chk("rst_nuds", 32'(nUDS), 32'd1);
    chk("rst_nlds", 32'(nLDS), 32'd1);
    chk("rst_rw", 32'(M68K_RW), 32'd1);
    chk("rst_addr", 32'(M68K_ADDR), 32'd0);
    chk("rst_dout", 32'(M68K_DOUT), 32'd0);
    chk("rst_rdata", 32'(RDATA), 32'd0);
    chk("rst_flags", {28'd0, M68K_DOUT_EN, BUSY, ACK, BERR}, 32'd0);
    nRESET = 1'b1;

    // Zero-wait read.
    dmode = 0; M68K_DIN = 16'hA55A;
    issue(RW_READ, 23'h000100, 16'h0, 2'b11, 3, 1'b0, 16'hA55A, "rd0", 0, e0);
    chk("rd0_busy", 32'(BUSY), 32'd1);
    wait_e(e0 + 1);
    chk("rd0_strobes_e1", {29'd0, nAS, nUDS, nLDS}, 32'd0);
    chk("rd0_addr", 32'(M68K_ADDR), 32'h100);
    chk("rd0_rw", 32'(M68K_RW), 32'd1);
    wait_e(e0 + 2);
    chk("rd0_nas_e2", 32'(nAS), 32'd0);
    wait_e(e0 + 3);
    chk("rd0_nas_e3", 32'(nAS), 32'd1);
    wait_drain();

    // Read through a wait-state zone.
    dmode = 1; M68K_DIN = 16'h1357;
    issue(RW_READ, 23'h012345, 16'h0, 2'b11, 5, 1'b0, 16'h1357, "zone", 0, e0);
    wait_e(e0 + 2);
    chk("zone_dtack_e2", 32'(nDTACK), 32'd1);
    wait_e(e0 + 3);
    chk("zone_dtack_e3", 32'(nDTACK), 32'd0);
    wait_drain();

    // Upper-byte write; RDATA keeps the previous read.
    dmode = 0; M68K_DIN = 16'hFFFF;
    issue(RW_WRITE, 23'h2AAAA, 16'h1234, 2'b10, 4, 1'b0, 16'h1357, "wr", 0, e0);
    wait_e(e0 + 1);
    chk("wr_e1_douten", 32'(M68K_DOUT_EN), 32'd1);
    chk("wr_e1_dout", 32'(M68K_DOUT), 32'h1234);
    chk("wr_e1_strobes", {29'd0, nAS, nUDS, nLDS}, 32'b011);
    chk("wr_e1_rw", 32'(M68K_RW), 32'd0);
    wait_e(e0 + 2);
    chk("wr_e2_strobes", {29'd0, nAS, nUDS, nLDS}, 32'b001);
    wait_e(e0 + 3);
    chk("wr_e3_douten", 32'(M68K_DOUT_EN), 32'd1);
    wait_e(e0 + 4);
    chk("wr_e4_douten", 32'(M68K_DOUT_EN), 32'd0);
    chk("wr_e4_strobes", {29'd0, nAS, nUDS, nLDS, M68K_RW}, 32'b1111);
    wait_drain();

    // Watchdog timeout, then a clean read.
    dmode = 2; M68K_DIN = 16'hDEAD;
    issue(RW_READ, 23'h000200, 16'h0, 2'b11, 66, 1'b1, 16'h1357, "tmo", 0, e0);
    wait_e(e0 + 65);
    chk("tmo_e65_nas", 32'(nAS), 32'd0);
    wait_e(e0 + 66);
    chk("tmo_e66_strobes", {29'd0, nAS, nUDS, nLDS}, 32'b111);
    wait_drain();
    dmode = 0; M68K_DIN = 16'h2468;
    issue(RW_READ, 23'h000202, 16'h0, 2'b11, 3, 1'b0, 16'h2468, "post_tmo", 0, e0);
    wait_drain();

    // REQ held for three back-to-back reads.
    M68K_DIN = 16'hBEEF;
    issue(RW_READ, 23'h000300, 16'h0, 2'b11, 3, 1'b0, 16'hBEEF, "b2b0", 1, e0);
    sb_q.push_back('{ack_e: e0 + 7,  berr: 1'b0, rdata: 16'hBEEF, tag: "b2b1"});
    sb_q.push_back('{ack_e: e0 + 11, berr: 1'b0, rdata: 16'hBEEF, tag: "b2b2"});
    wait_e(e0 + 3);
    chk("b2b_e3_nas", 32'(nAS), 32'd1);
    wait_e(e0 + 4);
    chk("b2b_e4_nas", 32'(nAS), 32'd1);
    chk("b2b_e4_busy", 32'(BUSY), 32'd1);
    wait_e(e0 + 5);
    chk("b2b_e5_nas", 32'(nAS), 32'd0);
    wait_e(e0 + 8);
    REQ = 1'b0;
    wait_drain();
    wait_e(e0 + 14);
    chk("b2b_idle_busy", 32'(BUSY), 32'd0);

    // No byte lanes: completes without a bus cycle.
    issue(RW_READ, 23'h000055, 16'h0, 2'b00, 1, 1'b0, 16'hBEEF, "be0", 0, e0);
    chk("be0_nas", 32'(nAS), 32'd1);
    wait_drain();

    // Reset in the middle of WAIT.
    dmode = 2;
    issue(RW_READ, 23'h000400, 16'h0, 2'b01, 100, 1'b0, 16'h0, "rstmid", 0, e0);
    sb_q.delete();
    wait_e(e0 + 5);
    chk("rstmid_nlds_before", 32'(nLDS), 32'd0);
    #2;
    nRESET = 1'b0;
    #1;
    chk("rstmid_strobes", {29'd0, nAS, nUDS, nLDS}, 32'b111);
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    chk("rstmid_ack", 32'(ACK), 32'd0);
    repeat (4) @(negedge CLK);
    nRESET = 1'b1;
    dmode = 0; M68K_DIN = 16'h7E7E;
    issue(RW_READ, 23'h000402, 16'h0, 2'b11, 3, 1'b0, 16'h7E7E, "post_rst", 0, e0);
    wait_drain();
    repeat (6) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (E=%0d)", e_num);
    $fatal(1, "global timeout");
  end

endmodule
